ip2_test3_sweep_ctrl: RTL and testbench

- Scheduler that drives the IP2 test3 sequencer (reset / trig-out / scan-load capture) through an automatic sweep of scan_load_delay.
- For each sweep point it issues one test-start pulse, waits for the test's done flag, and pushes {delay, dnn_output_0, dnn_output_1} into a small result FIFO.
- Software drains the FIFO through a valid/ready port.
- Sits between the AXI register file and the test3 state machine; all logic runs on the 400 MHz fast clock.

---
 rtl/ip2_test3_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ip2_test3_sweep_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip2_test3_sweep_ctrl.sv
// Sweep scheduler for the IP2 test3 sequencer: steps scan_load_delay over a range,
// fires one test per point and queues {delay, dnn0, dnn1} for software to drain.
module ip2_test3_sweep_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sweep_start,
    input  logic          sweep_abort,
    input  logic [5:0]    delay_first,
    input  logic [5:0]    delay_last,
    input  logic [5:0]    delay_step,
    input  logic          test_status_done,
    input  logic [47:0]   dnn_output_0,
    input  logic [47:0]   dnn_output_1,
    output logic          test_start_re,
    output logic [5:0]    scan_load_delay,
    output logic          scan_load_delay_disable,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [101:0]  rd_data,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic          timeout_err,
    output logic          cfg_err,
    output logic [2:0]    sm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_STEP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cur_delay_q, cur_delay_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            sweep_done_q, sweep_done_d;
    logic            timeout_err_q, timeout_err_d;
    logic            cfg_err_q, cfg_err_d;
    logic            start_prev_q, done_prev_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [101:0]    mem_q [FIFO_DEPTH];

    logic            start_edge, done_edge, fifo_full, fifo_empty;
    logic            start_pulse, push, pop, flush, halt;
    logic [6:0]      nxt_delay;

    assign start_edge = sweep_start & ~start_prev_q;
    assign done_edge  = test_status_done & ~done_prev_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = ~fifo_empty & rd_ready;
    assign nxt_delay  = {1'b0, cur_delay_q} + {1'b0, delay_step};
    assign halt       = ~enable | sweep_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cur_delay_q   <= '0;
            tmo_cnt_q     <= '0;
            sweep_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            start_prev_q  <= 1'b0;
            done_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_delay_q   <= cur_delay_d;
            tmo_cnt_q     <= tmo_cnt_d;
            sweep_done_q  <= sweep_done_d;
            timeout_err_q <= timeout_err_d;
            cfg_err_q     <= cfg_err_d;
            start_prev_q  <= sweep_start;
            done_prev_q   <= test_status_done;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_delay_d   = cur_delay_q;
        tmo_cnt_d     = tmo_cnt_q;
        sweep_done_d  = sweep_done_q;
        timeout_err_d = timeout_err_q;
        cfg_err_d     = cfg_err_q;
        start_pulse   = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        if (halt) begin
            state_d      = S_IDLE;
            sweep_done_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        if (delay_step == 6'd0 || delay_first > delay_last) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            flush         = 1'b1;
                            sweep_done_d  = 1'b0;
                            timeout_err_d = 1'b0;
                            cfg_err_d     = 1'b0;
                            cur_delay_d   = delay_first;
                            state_d       = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (!fifo_full) begin
                        start_pulse = 1'b1;
                        tmo_cnt_d   = CNT_TOP;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Last counted cycle is the one where the counter reads 1.
                    if (done_edge) begin
                        state_d = S_CAPTURE;
                    end else if (tmo_cnt_q <= CNT_ONE) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    push    = 1'b1;
                    state_d = S_STEP;
                end
                S_STEP: begin
                    if (nxt_delay > {1'b0, delay_last}) begin
                        sweep_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        cur_delay_d = nxt_delay[5:0];
                        state_d     = S_ARM;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cur_delay_q, dnn_output_0, dnn_output_1};
    end

    assign test_start_re           = start_pulse;
    assign scan_load_delay         = cur_delay_q;
    assign scan_load_delay_disable = 1'b0;
    assign rd_valid                = ~fifo_empty;
    assign rd_data                 = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign sweep_busy              = ~halt && (state_q == S_ARM || state_q == S_WAIT ||
                                               state_q == S_CAPTURE || state_q == S_STEP);
    assign sweep_done              = sweep_done_q;
    assign timeout_err             = timeout_err_q;
    assign cfg_err                 = cfg_err_q;
    assign sm_state                = state_q;

endmodule

// File: tb/tb_ip2_test3_sweep_ctrl.sv
// Scoreboard bench for ip2_test3_sweep_ctrl with a behavioural test3 done model.
module tb_ip2_test3_sweep_ctrl;

    localparam int TO  = 32;
    localparam int DEP = 4;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          reset, enable, sweep_start, sweep_abort;
    logic [5:0]    delay_first, delay_last, delay_step;
    logic          test_status_done;
    logic [47:0]   dnn_output_0, dnn_output_1;
    logic          test_start_re, scan_load_delay_disable, rd_valid, rd_ready;
    logic [5:0]    scan_load_delay;
    logic [101:0]  rd_data;
    logic          sweep_busy, sweep_done, timeout_err, cfg_err;
    logic [2:0]    sm_state;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_starts = 0;
    int            cyc      = 0;
    int            pulse_cyc = 0;
    bit            done_en  = 1'b1;
    bit            busy_seen = 1'b0;
    logic [101:0]  exp_q [$];
    int            lat_cnt, hold_cnt;
    logic [5:0]    model_d;
    logic [101:0]  got_w;

    ip2_test3_sweep_ctrl #(.FIFO_DEPTH(DEP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sweep_start(sweep_start),
        .sweep_abort(sweep_abort), .delay_first(delay_first), .delay_last(delay_last),
        .delay_step(delay_step), .test_status_done(test_status_done),
        .dnn_output_0(dnn_output_0), .dnn_output_1(dnn_output_1),
        .test_start_re(test_start_re), .scan_load_delay(scan_load_delay),
        .scan_load_delay_disable(scan_load_delay_disable), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .timeout_err(timeout_err), .cfg_err(cfg_err),
        .sm_state(sm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] f0(input logic [5:0] d);
        return {24'hC0FFEE, 18'h0, d};
    endfunction
    function automatic logic [47:0] f1(input logic [5:0] d);
        return {18'h0, d, 24'h5A5A5A};
    endfunction
    function automatic logic [101:0] word(input logic [5:0] d);
        return {d, f0(d), f1(d)};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [5:0] f, input logic [5:0] l, input logic [5:0] s);
        delay_first = f;
        delay_last  = l;
        delay_step  = s;
        sweep_start = 1'b1;
        step(2);
        sweep_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        while (sm_state != 3'd0 && k < maxc) begin
            step(1);
            k++;
        end
        if (k >= maxc) bound_fail(nm);
    endtask

    // test3 model: done rises LAT cycles after each start pulse, with the DNN words for that delay
    initial begin
        test_status_done = 1'b0;
        dnn_output_0 = '0;
        dnn_output_1 = '0;
        lat_cnt = 0;
        hold_cnt = 0;
        model_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lat_cnt = 0;
                hold_cnt = 0;
                test_status_done = 1'b0;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) test_status_done = 1'b0;
                end
                if (test_start_re) begin
                    n_starts++;
                    pulse_cyc = cyc;
                    model_d = scan_load_delay;
                    lat_cnt = done_en ? LAT : 0;
                end else if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        dnn_output_0 = f0(model_d);
                        dnn_output_1 = f1(model_d);
                        test_status_done = 1'b1;
                        hold_cnt = 3;
                    end
                end
            end
        end
    end

    // Monitor: every accepted FIFO read is compared against the oldest expected word
    initial begin
        forever begin
            @(negedge clk);
            if (sweep_busy) busy_seen = 1'b1;
            if (!reset && rd_valid && rd_ready) begin
                got_w = rd_data;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", {26'h0, got_w}, 128'h0);
                end else begin
                    check("sb_rd_data", {26'h0, got_w}, {26'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; sweep_start = 1'b0; sweep_abort = 1'b0;
        delay_first = '0; delay_last = '0; delay_step = '0; rd_ready = 1'b0;
        step(3);
        check("rst_state", sm_state, 3'd0);
        check("rst_start", test_start_re, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 102'h0);
        check("rst_flags", {sweep_busy, sweep_done, timeout_err, cfg_err}, 4'h0);
        check("rst_delay", {scan_load_delay_disable, scan_load_delay}, 7'h0);
        reset = 1'b0;
        enable = 1'b1;
        step(2);

        // three-point sweep 0,4,8
        rd_ready = 1'b1;
        n_starts = 0;
        exp_q.push_back(word(6'd0));
        exp_q.push_back(word(6'd4));
        exp_q.push_back(word(6'd8));
        start_sweep(6'd0, 6'd8, 6'd4);
        check("t1_busy", sweep_busy, 1'b1);
        wait_idle(300, "t1_idle");
        check("t1_done", sweep_done, 1'b1);
        check("t1_starts", n_starts, 3);
        check("t1_errs", {timeout_err, cfg_err}, 2'b00);
        step(3);
        check("t1_drained", exp_q.size(), 0);

        // 7-bit step compare: 60+5 ends the sweep
        n_starts = 0;
        exp_q.push_back(word(6'd60));
        start_sweep(6'd60, 6'd63, 6'd5);
        wait_idle(200, "t2_idle");
        check("t2_done", sweep_done, 1'b1);
        check("t2_starts", n_starts, 1);
        check("t2_delay", scan_load_delay, 6'd60);
        step(3);
        check("t2_drained", exp_q.size(), 0);

        // configuration errors
        n_starts = 0;
        busy_seen = 1'b0;
        start_sweep(6'd10, 6'd5, 6'd1);
        step(2);
        check("t3_cfg_order", cfg_err, 1'b1);
        check("t3_state", sm_state, 3'd0);
        exp_q.push_back(word(6'd2));
        start_sweep(6'd2, 6'd2, 6'd1);
        wait_idle(200, "t3_ok_idle");
        check("t3_cfg_cleared", {cfg_err, sweep_done}, 2'b01);
        step(3);
        n_starts = 0;
        busy_seen = 1'b0;
        start_sweep(6'd0, 6'd8, 6'd0);
        step(2);
        check("t3_cfg_step0", cfg_err, 1'b1);
        check("t3_no_pulse", n_starts, 0);
        check("t3_no_busy", busy_seen, 1'b0);

        // timeout: done never rises
        done_en = 1'b0;
        n_starts = 0;
        start_sweep(6'd5, 6'd20, 6'd3);
        begin
            int k = 0;
            while (!timeout_err && k < TO + 40) begin
                step(1);
                k++;
            end
            if (k >= TO + 40) bound_fail("t4_timeout_wait");
        end
        check("t4_latency", cyc - pulse_cyc, TO + 1);
        check("t4_state", sm_state, 3'd0);
        check("t4_fifo_empty", rd_valid, 1'b0);
        check("t4_starts", n_starts, 1);
        check("t4_not_done", sweep_done, 1'b0);
        done_en = 1'b1;

        // FIFO full stall then release
        rd_ready = 1'b0;
        n_starts = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(word(6'(i)));
        start_sweep(6'd0, 6'd5, 6'd1);
        step(150);
        check("t5_stall_state", sm_state, 3'd1);
        check("t5_stall_starts", n_starts, 4);
        check("t5_stall_flags", {rd_valid, sweep_busy, test_start_re}, 3'b110);
        rd_ready = 1'b1;
        wait_idle(300, "t5_idle");
        check("t5_done", sweep_done, 1'b1);
        check("t5_starts", n_starts, 6);
        step(3);
        check("t5_drained", exp_q.size(), 0);

        // abort in WAIT_DONE
        n_starts = 0;
        start_sweep(6'd0, 6'd8, 6'd4);
        step(5);
        check("t6_in_wait", sm_state, 3'd2);
        sweep_abort = 1'b1;
        step(1);
        sweep_abort = 1'b0;
        check("t6_abort_state", sm_state, 3'd0);
        check("t6_abort_flags", {sweep_busy, sweep_done, timeout_err, cfg_err}, 4'h0);
        step(30);
        check("t6_abort_quiet", {rd_valid, sm_state}, 4'h0);

        // async reset mid-sweep with a non-empty FIFO
        rd_ready = 1'b0;
        exp_q.push_back(word(6'd0));
        start_sweep(6'd0, 6'd8, 6'd4);
        begin
            int k = 0;
            while (!rd_valid && k < 80) begin
                step(1);
                k++;
            end
            if (k >= 80) bound_fail("t7_push_wait");
        end
        step(3);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_state", sm_state, 3'd0);
        check("t7_rst_fifo", {rd_valid, rd_data}, 103'h0);
        check("t7_rst_out", {test_start_re, sweep_busy, sweep_done, scan_load_delay}, 9'h0);
        exp_q.delete();
        step(2);
        reset = 1'b0;
        rd_ready = 1'b1;
        step(5);
        check("t7_after_rst", {rd_valid, sm_state}, 4'h0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
